// File: rtl/seq_divider16_if.sv
// Start/busy/done handshake and operand/result bus for the sequential divider.
// The master drives the request and operands; the slave returns status and results.
interface seq_divider16_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider16.sv
// Iterative unsigned restoring divider: one quotient bit per clock.
// A zero divisor skips iteration and reports saturated quotient plus div_by_zero.
module seq_divider16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_divider16_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned EXT_W = WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [EXT_W-1:0] shifted_c;
    logic [EXT_W-1:0] trial_c;
    logic             fits_c;
    logic [WIDTH-1:0] rem_step_c;
    logic [WIDTH-1:0] quo_step_c;

    // One restoring step: shift in the next dividend bit and try subtracting the divisor.
    always_comb begin
        shifted_c  = {rem_q, quo_q[WIDTH-1]};
        trial_c    = shifted_c + ~{1'b0, div_q} + EXT_W'(1);
        fits_c     = ~trial_c[WIDTH];
        rem_step_c = fits_c ? trial_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];
        quo_step_c = {quo_q[WIDTH-2:0], fits_c};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and datapath control; results only move on the completing edge.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        state_d = ST_RUN;
                        div_d   = bus.divisor;
                        rem_d   = '0;
                        quo_d   = bus.dividend;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                    end else begin
                        state_d     = ST_DONE;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                rem_d = rem_step_c;
                quo_d = quo_step_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = ST_DONE;
                    quotient_d  = quo_step_c;
                    remainder_d = rem_step_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider16.sv
// Self-checking bench for seq_divider16: directed cases plus random operands
// compared against plain / and % arithmetic.
module tb_seq_divider16;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned LAT   = 16;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_r;

    seq_divider16_if #(.WIDTH(WIDTH)) bus ();

    seq_divider16 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for done; optionally pulses an ignored start mid-run.
    task automatic wait_done(input int exp_lat, input logic [WIDTH-1:0] eq,
                             input logic [WIDTH-1:0] er, input logic edz,
                             input int pulse_at);
        int n;
        n = 0;
        while (!bus.done && n < 40) begin
            chk("run_busy", 32'(bus.busy), 32'd1);
            chk("run_q_hold", 32'(bus.quotient), 32'(prev_q));
            chk("run_r_hold", 32'(bus.remainder), 32'(prev_r));
            if (pulse_at >= 0 && n == pulse_at) begin
                bus.start    = 1'b1;
                bus.dividend = 16'd50;
                bus.divisor  = 16'd5;
            end
            if (pulse_at >= 0 && n == pulse_at + 1) bus.start = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 32'(n), 32'(exp_lat));
        chk("quotient", 32'(bus.quotient), 32'(eq));
        chk("remainder", 32'(bus.remainder), 32'(er));
        chk("dbz", 32'(bus.div_by_zero), 32'(edz));
        chk("done_busy_low", 32'(bus.busy), 32'd0);
        prev_q = eq;
        prev_r = er;
    endtask

    // Single operation from idle, with expectations from plain arithmetic.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int pulse_at);
        logic [WIDTH-1:0] eq;
        logic [WIDTH-1:0] er;
        int               lat;
        if (b == '0) begin
            eq  = '1;
            er  = a;
            lat = 0;
        end else begin
            eq  = a / b;
            er  = a % b;
            lat = LAT;
        end
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 16'($urandom);
        wait_done(lat, eq, er, (b == '0), pulse_at);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("idle_q_held", 32'(bus.quotient), 32'(eq));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        total = 0;
        bad   = 0;
        prev_q = '0;
        prev_r = '0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_q", 32'(bus.quotient), 32'd0);
        chk("rst_r", 32'(bus.remainder), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_op(16'd100, 16'd7, -1);
        run_op(16'hFFFF, 16'd1, -1);
        run_op(16'hFFFF, 16'hFFFF, -1);
        run_op(16'd3, 16'd10, -1);
        run_op(16'd5, 16'd0, -1);
        chk("dbz_held_idle", 32'(bus.div_by_zero), 32'd1);
        run_op(16'd9, 16'd3, -1);
        run_op(16'd1000, 16'd9, 5);

        // Start held through DONE: second op accepted with no idle gap.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd200;
        bus.divisor  = 16'd3;
        @(posedge clk);
        #1;
        bus.dividend = 16'd1234;
        bus.divisor  = 16'd56;
        wait_done(LAT, 16'd66, 16'd2, 1'b0, -1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        chk("b2b_q_stable", 32'(bus.quotient), 32'd66);
        @(posedge clk);
        #1;
        wait_done(LAT - 1, 16'd22, 16'd2, 1'b0, -1);

        // Reset mid-run aborts the op.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd40000;
        bus.divisor  = 16'd123;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_q", 32'(bus.quotient), 32'd0);
        chk("abort_r", 32'(bus.remainder), 32'd0);
        chk("abort_dbz", 32'(bus.div_by_zero), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        prev_q = '0;
        prev_r = '0;
        run_op(16'd40000, 16'd123, -1);

        // Random operands, with small and zero divisors mixed in.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = '0;
                1, 2, 3: rb = 16'($urandom_range(1, 15));
                4:       rb = 16'($urandom_range(0, 255)) + ra;
                default: rb = 16'($urandom);
            endcase
            run_op(ra, rb, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
